// File: rtl/cp0_spi_ctrl.sv
// cp0_spi_ctrl: CP0-mapped SPI master with DATA/STATUS/CTRL registers and a CPU stall on busy DATA access.
module cp0_spi_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int W_DATA  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  spi_mode,
  input  logic        cp0_wen,
  input  logic        cp0_ren,
  input  logic [4:0]  cp0_sel,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  output logic        stall,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        cs_n
);
  localparam int EW = $clog2(2*W_DATA+1);
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_e;
  state_e state_q, state_d;
  logic [W_DATA-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic [1:0] mode_q, mode_d;
  logic [7:0] div_cnt_q, div_cnt_d;
  logic [EW-1:0] edge_cnt_q, edge_cnt_d, edge_nx;
  logic rx_valid_q, rx_valid_d, cs_hold_q, cs_hold_d;
  logic sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d;
  logic busy, sel_data, data_wr, data_rd, ctrl_wr, tick, fire, lead;
  logic unused_ok;
  assign unused_ok = ^cp0_wdata;
  assign busy     = state_q != IDLE;
  assign sel_data = cp0_sel == 5'd0;
  assign stall    = busy & (cp0_wen | cp0_ren) & sel_data;
  assign data_wr  = cp0_wen & sel_data & ~busy;
  assign data_rd  = cp0_ren & sel_data & ~busy;
  assign ctrl_wr  = cp0_wen & (cp0_sel == 5'd2);
  assign tick     = div_cnt_q == 8'(CLK_DIV-1);
  // The SETUP-exit tick is SCLK edge 1; SHIFT spends its last half-period idle at CPOL.
  assign fire     = tick & ((state_q == SETUP) | ((state_q == SHIFT) & (edge_cnt_q != EW'(2*W_DATA))));
  assign edge_nx  = edge_cnt_q + 1'b1;
  assign lead     = edge_nx[0];
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;
  always_comb
    cp0_rdata = !cp0_ren ? 32'd0 :
                sel_data ? 32'(rx_data_q) :
                (cp0_sel == 5'd1) ? {30'd0, rx_valid_q, busy} :
                (cp0_sel == 5'd2) ? {31'd0, cs_hold_q} : 32'd0;
  always_comb begin
    state_d    = state_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q & ~data_rd;
    mode_d     = mode_q;
    cs_hold_d  = ctrl_wr ? cp0_wdata[0] : cs_hold_q;
    div_cnt_d  = (busy & ~tick) ? div_cnt_q + 8'd1 : 8'd0;
    edge_cnt_d = fire ? edge_nx : edge_cnt_q;
    sclk_d     = fire ? ~sclk_q : sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    case (state_q)
      IDLE: begin
        sclk_d = mode_q[1];
        cs_n_d = ~cs_hold_d;
        if (data_wr) begin
          state_d    = SETUP;
          tx_sh_d    = cp0_wdata[W_DATA-1:0];
          mode_d     = spi_mode;
          rx_valid_d = 1'b0;
          edge_cnt_d = '0;
          sclk_d     = spi_mode[1];
          cs_n_d     = 1'b0;
          mosi_d     = spi_mode[0] ? mosi_q : cp0_wdata[W_DATA-1];
        end
      end
      SETUP: state_d = tick ? SHIFT : SETUP;
      SHIFT: state_d = (tick & (edge_cnt_q == EW'(2*W_DATA))) ? HOLD : SHIFT;
      HOLD: if (tick) begin
        state_d    = IDLE;
        rx_data_d  = rx_sh_q;
        rx_valid_d = 1'b1;
        cs_n_d     = ~cs_hold_d;
      end
      default: state_d = IDLE;
    endcase
    // CPHA flips which edge samples; CPHA=0 skips the launch on the final trailing edge.
    if (fire) begin
      if (lead ^ mode_q[0])
        rx_sh_d = {rx_sh_q[W_DATA-2:0], miso};
      else if (mode_q[0] | (edge_nx != EW'(2*W_DATA))) begin
        mosi_d  = mode_q[0] ? tx_sh_q[W_DATA-1] : tx_sh_q[W_DATA-2];
        tx_sh_d = tx_sh_q << 1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      mode_q     <= 2'd0;
      cs_hold_q  <= 1'b0;
      div_cnt_q  <= 8'd0;
      edge_cnt_q <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      mode_q     <= mode_d;
      cs_hold_q  <= cs_hold_d;
      div_cnt_q  <= div_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
    end
  end
endmodule
